// File: rtl/control_unit_pkg.sv
// Shared types and constants for the microcoded control unit.
package control_unit_pkg;

    localparam int unsigned IR_width  = 12;
    localparam int unsigned Reg_count = 16;
    localparam int unsigned REG_IDX_W = 4;

    typedef enum logic [4:0] {
        IDLE, FETCH1, FETCH2,
        CLR1, LOAD1, LOAD2, MUL1, ADD1, SUB1, INC1,
        JUMP1, JUMP2, JUMPZY1, JUMPZY2, JUMPZN1,
        MVAC1, MOV1, STORE1, STORE2,
        LOAD_REG1, LOAD_REG2, LOAD_REG3, ENDOP1
    } state_t;

    typedef enum logic [2:0] {
        ALU_NONE = 3'b000,
        ALU_ADD  = 3'b001,
        ALU_SUB  = 3'b010,
        ALU_MUL  = 3'b011,
        ALU_INC  = 3'b100,
        ALU_CLR  = 3'b101
    } alu_op_t;

    typedef enum logic [1:0] {
        MR_NONE  = 2'b00,
        MR_DATA  = 2'b01,
        MR_INSTR = 2'b10
    } mem_read_t;

    // Register-file bit positions shared by read_en and write_en
    localparam logic [REG_IDX_W-1:0] REG_PC     = 4'd0;
    localparam logic [REG_IDX_W-1:0] REG_AR     = 4'd1;
    localparam logic [REG_IDX_W-1:0] REG_DR     = 4'd2;
    localparam logic [REG_IDX_W-1:0] REG_IR     = 4'd3;
    localparam logic [REG_IDX_W-1:0] REG_AC     = 4'd4;
    localparam logic [REG_IDX_W-1:0] REG_TOTAL  = 4'd5;
    localparam logic [REG_IDX_W-1:0] REG_ALPHAP = 4'd6;
    localparam logic [REG_IDX_W-1:0] REG_BETAP  = 4'd7;
    localparam logic [REG_IDX_W-1:0] REG_GAMMAP = 4'd8;
    localparam logic [REG_IDX_W-1:0] REG_R      = 4'd9;
    localparam logic [REG_IDX_W-1:0] REG_ROW    = 4'd10;
    localparam logic [REG_IDX_W-1:0] REG_CAT    = 4'd11;
    localparam logic [REG_IDX_W-1:0] REG_CB     = 4'd12;
    localparam logic [REG_IDX_W-1:0] REG_RNOW   = 4'd13;
    localparam logic [REG_IDX_W-1:0] REG_CATNOW = 4'd14;
    localparam logic [REG_IDX_W-1:0] REG_CBNOW  = 4'd15;

    localparam logic [IR_width-1:0] OP_CLR        = IR_width'(0);
    localparam logic [IR_width-1:0] OP_LOAD       = IR_width'(1);
    localparam logic [IR_width-1:0] OP_MUL        = IR_width'(2);
    localparam logic [IR_width-1:0] OP_ADD        = IR_width'(3);
    localparam logic [IR_width-1:0] OP_SUB        = IR_width'(4);
    localparam logic [IR_width-1:0] OP_INC        = IR_width'(5);
    localparam logic [IR_width-1:0] OP_JUMP       = IR_width'(6);
    localparam logic [IR_width-1:0] OP_JUMPZ      = IR_width'(7);
    localparam logic [IR_width-1:0] OP_MVAC_FIRST = IR_width'(8);
    localparam logic [IR_width-1:0] OP_MVAC_LAST  = IR_width'(18);
    localparam logic [IR_width-1:0] OP_MOV_FIRST  = IR_width'(19);
    localparam logic [IR_width-1:0] OP_MOV_LAST   = IR_width'(29);
    localparam logic [IR_width-1:0] OP_STORE      = IR_width'(30);
    localparam logic [IR_width-1:0] OP_LOAD_REG   = IR_width'(31);
    localparam logic [IR_width-1:0] OP_ENDOP      = IR_width'(32);

    typedef struct packed {
        alu_op_t                alu_op;
        logic [Reg_count-1:0]   read_en;
        logic [Reg_count-1:0]   write_en;
        logic                   mem_write;
        logic                   pc_inc;
        mem_read_t              mem_read;
    } ctrl_t;

endpackage

// File: rtl/control_unit_if.sv
// Control bus between the control unit (master) and the datapath (slave).
interface control_unit_if;
    import control_unit_pkg::*;

    logic                   Zflag;
    logic                   start;
    logic [IR_width-1:0]    opcode;
    alu_op_t                alu_op;
    logic [Reg_count-1:0]   read_en;
    logic [Reg_count-1:0]   write_en;
    logic                   mem_write;
    logic                   PC_Inc;
    mem_read_t              mem_read;

    modport master (
        input  Zflag, start, opcode,
        output alu_op, read_en, write_en, mem_write, PC_Inc, mem_read
    );

    modport slave (
        output Zflag, start, opcode,
        input  alu_op, read_en, write_en, mem_write, PC_Inc, mem_read
    );

endinterface

// File: rtl/control_unit.sv
// Moore microcoded sequencer: fetch, decode, 1-3 execute states per instruction.
module control_unit
    import control_unit_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    control_unit_if.master      bus
);

    state_t                 state, state_nxt;
    logic [REG_IDX_W-1:0]   reg_idx, reg_idx_nxt;
    ctrl_t                  outs;

    // Execute entry state for an opcode; unknown opcodes fall back to fetch
    function automatic state_t decode_op(input logic [IR_width-1:0] op, input logic z);
        state_t s;
        s = FETCH1;
        if (op >= OP_MVAC_FIRST && op <= OP_MVAC_LAST) begin
            s = MVAC1;
        end else if (op >= OP_MOV_FIRST && op <= OP_MOV_LAST) begin
            s = MOV1;
        end else begin
            case (op)
                OP_CLR:      s = CLR1;
                OP_LOAD:     s = LOAD1;
                OP_MUL:      s = MUL1;
                OP_ADD:      s = ADD1;
                OP_SUB:      s = SUB1;
                OP_INC:      s = INC1;
                OP_JUMP:     s = JUMP1;
                OP_JUMPZ:    s = z ? JUMPZN1 : JUMPZY1;
                OP_STORE:    s = STORE1;
                OP_LOAD_REG: s = LOAD_REG1;
                OP_ENDOP:    s = ENDOP1;
                default:     s = FETCH1;
            endcase
        end
        return s;
    endfunction

    // MVAC/MOV operand register: opcode offset within its group, rebased at total
    function automatic logic [REG_IDX_W-1:0] reg_sel(input logic [IR_width-1:0] op);
        if (op <= OP_MVAC_LAST)
            return REG_IDX_W'(op - OP_MVAC_FIRST) + REG_TOTAL;
        else
            return REG_IDX_W'(op - OP_MOV_FIRST) + REG_TOTAL;
    endfunction

    // Control word asserted while sitting in a given state
    function automatic ctrl_t ctrl_out(input state_t s, input logic [REG_IDX_W-1:0] idx);
        ctrl_t o;
        o = '0;
        case (s)
            FETCH1, LOAD1, JUMP1, JUMPZY1: begin
                o.read_en[REG_PC] = 1'b1;
                o.mem_read        = MR_INSTR;
            end
            FETCH2: begin
                o.write_en[REG_IR] = 1'b1;
                o.pc_inc           = 1'b1;
            end
            CLR1: begin
                o.alu_op           = ALU_CLR;
                o.write_en[REG_AC] = 1'b1;
            end
            LOAD2: begin
                o.write_en[REG_AR] = 1'b1;
                o.pc_inc           = 1'b1;
            end
            MUL1, ADD1, SUB1: begin
                o.read_en[REG_R]   = 1'b1;
                o.write_en[REG_AC] = 1'b1;
                o.alu_op = (s == MUL1) ? ALU_MUL : ((s == ADD1) ? ALU_ADD : ALU_SUB);
            end
            INC1: begin
                o.alu_op           = ALU_INC;
                o.write_en[REG_AC] = 1'b1;
            end
            JUMP2, JUMPZY2: o.write_en[REG_PC] = 1'b1;
            JUMPZN1:        o.pc_inc = 1'b1;
            MVAC1: begin
                o.read_en[REG_AC] = 1'b1;
                o.write_en[idx]   = 1'b1;
            end
            MOV1: begin
                o.read_en[idx]     = 1'b1;
                o.write_en[REG_AC] = 1'b1;
            end
            STORE1: begin
                o.read_en[REG_AC]  = 1'b1;
                o.write_en[REG_DR] = 1'b1;
            end
            STORE2: begin
                o.read_en[REG_AR] = 1'b1;
                o.mem_write       = 1'b1;
            end
            LOAD_REG1: begin
                o.read_en[REG_AR] = 1'b1;
                o.mem_read        = MR_DATA;
            end
            LOAD_REG2: o.write_en[REG_DR] = 1'b1;
            LOAD_REG3: begin
                o.read_en[REG_DR]  = 1'b1;
                o.write_en[REG_AC] = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

    // Next-state and operand-register selection
    always_comb begin
        state_nxt   = state;
        reg_idx_nxt = reg_idx;
        case (state)
            IDLE:      if (bus.start) state_nxt = FETCH1;
            FETCH1:    state_nxt = FETCH2;
            FETCH2: begin
                state_nxt   = decode_op(bus.opcode, bus.Zflag);
                reg_idx_nxt = reg_sel(bus.opcode);
            end
            LOAD1:     state_nxt = LOAD2;
            JUMP1:     state_nxt = JUMP2;
            JUMPZY1:   state_nxt = JUMPZY2;
            STORE1:    state_nxt = STORE2;
            LOAD_REG1: state_nxt = LOAD_REG2;
            LOAD_REG2: state_nxt = LOAD_REG3;
            ENDOP1:    state_nxt = IDLE;
            default:   state_nxt = FETCH1;
        endcase
    end

    // State register with control word registered alongside it
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            reg_idx <= '0;
            outs    <= '0;
        end else begin
            state   <= state_nxt;
            reg_idx <= reg_idx_nxt;
            outs    <= ctrl_out(state_nxt, reg_idx_nxt);
        end
    end

    assign bus.alu_op    = outs.alu_op;
    assign bus.read_en   = outs.read_en;
    assign bus.write_en  = outs.write_en;
    assign bus.mem_write = outs.mem_write;
    assign bus.PC_Inc    = outs.pc_inc;
    assign bus.mem_read  = outs.mem_read;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: directed vector table, corner sequences, random programs.
module tb_control_unit;

    typedef struct packed {
        logic [2:0]  alu;
        logic [15:0] rd;
        logic [15:0] wr;
        logic        mw;
        logic        pci;
        logic [1:0]  mr;
    } outv_t;

    typedef struct {
        int    op;
        bit    z;
        int    n;
        outv_t e0;
        outv_t e1;
        outv_t e2;
        string name;
    } vec_t;

    localparam int PC = 0, AR = 1, DR = 2, IR = 3, AC = 4, R = 9;

    logic clk = 1'b0;
    logic reset;
    control_unit_if bus();

    control_unit dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    int    check_cnt = 0;
    int    pass_cnt  = 0;
    outv_t exp_q[$];
    vec_t  vecs[$];

    function automatic outv_t mk(input logic [2:0] alu, input logic [15:0] rd,
                                 input logic [15:0] wr, input logic mw,
                                 input logic pci, input logic [1:0] mr);
        outv_t v;
        v.alu = alu; v.rd = rd; v.wr = wr; v.mw = mw; v.pci = pci; v.mr = mr;
        return v;
    endfunction

    function automatic logic [15:0] oh(input int i);
        return 16'(1) << i;
    endfunction

    // Reference: execute-phase control words for one instruction, from the opcode table
    function automatic void model_push(input int op, input bit z);
        if (op == 0) begin
            exp_q.push_back(mk(3'd5, 0, oh(AC), 0, 0, 0));
        end else if (op == 1) begin
            exp_q.push_back(mk(0, oh(PC), 0, 0, 0, 2'd2));
            exp_q.push_back(mk(0, 0, oh(AR), 0, 1, 0));
        end else if (op >= 2 && op <= 4) begin
            exp_q.push_back(mk((op == 2) ? 3'd3 : ((op == 3) ? 3'd1 : 3'd2), oh(R), oh(AC), 0, 0, 0));
        end else if (op == 5) begin
            exp_q.push_back(mk(3'd4, 0, oh(AC), 0, 0, 0));
        end else if (op == 6 || (op == 7 && !z)) begin
            exp_q.push_back(mk(0, oh(PC), 0, 0, 0, 2'd2));
            exp_q.push_back(mk(0, 0, oh(PC), 0, 0, 0));
        end else if (op == 7) begin
            exp_q.push_back(mk(0, 0, 0, 0, 1, 0));
        end else if (op >= 8 && op <= 18) begin
            exp_q.push_back(mk(0, oh(AC), oh(op - 8 + 5), 0, 0, 0));
        end else if (op >= 19 && op <= 29) begin
            exp_q.push_back(mk(0, oh(op - 19 + 5), oh(AC), 0, 0, 0));
        end else if (op == 30) begin
            exp_q.push_back(mk(0, oh(AC), oh(DR), 0, 0, 0));
            exp_q.push_back(mk(0, oh(AR), 0, 1, 0, 0));
        end else if (op == 31) begin
            exp_q.push_back(mk(0, oh(AR), 0, 0, 0, 2'd1));
            exp_q.push_back(mk(0, 0, oh(DR), 0, 0, 0));
            exp_q.push_back(mk(0, oh(DR), oh(AC), 0, 0, 0));
        end else if (op == 32) begin
            // ENDOP1, then one IDLE cycle while start is held high
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
        end
    endfunction

    task automatic chk(input string name, input outv_t exp);
        outv_t act;
        act = {3'(bus.alu_op), bus.read_en, bus.write_en, bus.mem_write, bus.PC_Inc, 2'(bus.mem_read)};
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got alu=%b rd=%h wr=%h mw=%b pci=%b mr=%b, want alu=%b rd=%h wr=%h mw=%b pci=%b mr=%b",
                      name, act.alu, act.rd, act.wr, act.mw, act.pci, act.mr,
                      exp.alu, exp.rd, exp.wr, exp.mw, exp.pci, exp.mr);
    endtask

    // Runs one instruction starting at the next FETCH1, checking exp_q for execute cycles
    task automatic run_instr(input int op, input bit z, input string tag);
        int k;
        @(negedge clk);
        chk({tag, "/fetch1"}, mk(0, 16'h0001, 0, 0, 0, 2'b10));
        bus.opcode = 12'(op);
        bus.Zflag  = z;
        @(negedge clk);
        chk({tag, "/fetch2"}, mk(0, 0, 16'h0008, 0, 1, 0));
        k = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            chk($sformatf("%s/exec%0d", tag, k), exp_q.pop_front());
            k++;
        end
    endtask

    initial begin
        outv_t zero;
        zero = '0;

        vecs.push_back('{0,  0, 1, mk(3'b101, 0, 16'h0010, 0, 0, 0), zero, zero, "clr"});
        vecs.push_back('{1,  0, 2, mk(0, 16'h0001, 0, 0, 0, 2'b10), mk(0, 0, 16'h0002, 0, 1, 0), zero, "load"});
        vecs.push_back('{2,  0, 1, mk(3'b011, 16'h0200, 16'h0010, 0, 0, 0), zero, zero, "mul"});
        vecs.push_back('{3,  1, 1, mk(3'b001, 16'h0200, 16'h0010, 0, 0, 0), zero, zero, "add"});
        vecs.push_back('{4,  0, 1, mk(3'b010, 16'h0200, 16'h0010, 0, 0, 0), zero, zero, "sub"});
        vecs.push_back('{5,  0, 1, mk(3'b100, 0, 16'h0010, 0, 0, 0), zero, zero, "inc"});
        vecs.push_back('{6,  1, 2, mk(0, 16'h0001, 0, 0, 0, 2'b10), mk(0, 0, 16'h0001, 0, 0, 0), zero, "jump"});
        vecs.push_back('{7,  0, 2, mk(0, 16'h0001, 0, 0, 0, 2'b10), mk(0, 0, 16'h0001, 0, 0, 0), zero, "jumpz_taken"});
        vecs.push_back('{7,  1, 1, mk(0, 0, 0, 0, 1, 0), zero, zero, "jumpz_skip"});
        vecs.push_back('{8,  0, 1, mk(0, 16'h0010, 16'h0020, 0, 0, 0), zero, zero, "mvac_total"});
        vecs.push_back('{18, 0, 1, mk(0, 16'h0010, 16'h8000, 0, 0, 0), zero, zero, "mvac_cbnow"});
        vecs.push_back('{19, 0, 1, mk(0, 16'h0020, 16'h0010, 0, 0, 0), zero, zero, "mov_total"});
        vecs.push_back('{29, 0, 1, mk(0, 16'h8000, 16'h0010, 0, 0, 0), zero, zero, "mov_cbnow"});
        vecs.push_back('{30, 0, 2, mk(0, 16'h0010, 16'h0004, 0, 0, 0), mk(0, 16'h0002, 0, 1, 0, 0), zero, "store"});
        vecs.push_back('{31, 0, 3, mk(0, 16'h0002, 0, 0, 0, 2'b01), mk(0, 0, 16'h0004, 0, 0, 0),
                         mk(0, 16'h0004, 16'h0010, 0, 0, 0), "load_reg"});
        vecs.push_back('{32, 0, 2, zero, zero, zero, "endop_restart"});
        vecs.push_back('{33, 0, 0, zero, zero, zero, "nop33"});
        vecs.push_back('{4095, 1, 0, zero, zero, zero, "nop4095"});

        // Reset wins over start; IDLE then holds while start is low
        reset = 1'b0; bus.start = 1'b1; bus.opcode = '0; bus.Zflag = 1'b0;
        repeat (2) begin @(negedge clk); chk("reset_idle", zero); end
        reset = 1'b1; bus.start = 1'b0;
        repeat (2) begin @(negedge clk); chk("idle_hold", zero); end
        bus.start = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].n > 0) exp_q.push_back(vecs[i].e0);
            if (vecs[i].n > 1) exp_q.push_back(vecs[i].e1);
            if (vecs[i].n > 2) exp_q.push_back(vecs[i].e2);
            run_instr(vecs[i].op, vecs[i].z, vecs[i].name);
        end

        // ENDOP with start dropped: machine parks in IDLE until start returns
        @(negedge clk);
        chk("endop_park/fetch1", mk(0, 16'h0001, 0, 0, 0, 2'b10));
        bus.opcode = 12'd32;
        bus.start  = 1'b0;
        @(negedge clk);
        chk("endop_park/fetch2", mk(0, 0, 16'h0008, 0, 1, 0));
        @(negedge clk);
        chk("endop_park/endop1", zero);
        repeat (3) begin @(negedge clk); chk("endop_park/idle", zero); end
        bus.start = 1'b1;

        // Reset asserted during LOAD_REG2 aborts the instruction
        @(negedge clk);
        chk("abort/fetch1", mk(0, 16'h0001, 0, 0, 0, 2'b10));
        bus.opcode = 12'd31;
        @(negedge clk);
        chk("abort/fetch2", mk(0, 0, 16'h0008, 0, 1, 0));
        @(negedge clk);
        chk("abort/load_reg1", mk(0, 16'h0002, 0, 0, 0, 2'b01));
        @(negedge clk);
        chk("abort/load_reg2", mk(0, 0, 16'h0004, 0, 0, 0));
        reset = 1'b0;
        @(negedge clk);
        chk("abort/idle", zero);
        reset = 1'b1;

        // Random programs against the reference model
        for (int i = 0; i < 300; i++) begin
            int op;
            bit z;
            op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(33, 4095)) : int'($urandom_range(0, 32));
            z  = 1'($urandom_range(0, 1));
            model_push(op, z);
            run_instr(op, z, $sformatf("rnd%0d_op%0d_z%0d", i, op, z));
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
